// File: rtl/arb_mux.sv
// CHANNELS-way arbitrated multiplexer with a one-deep registered output and valid/ready handshake.
// Define ARB_MUX_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest eligible index wins.
module arb_mux #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 8,
    localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      force_en,
    input  logic [SEL_W-1:0]          force_sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

`ifdef ARB_MUX_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0]    data_q, data_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                valid_q, valid_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;

    logic                load;
    logic                transfer;
    logic [SEL_W:0]      force_sel_ext;
    logic                force_in_range;
    logic [CHANNELS-1:0] eligible;
    logic [SEL_W-1:0]    search_base;
    logic [SEL_W-1:0]    cand;
    logic                grant_valid;
    logic [SEL_W-1:0]    grant;

    assign load           = !valid_q || out_ready;
    assign force_sel_ext  = {1'b0, force_sel};
    assign force_in_range = force_sel_ext < CH_LIMIT;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!force_en) begin
                eligible[i] = in_valid[i];
            end else if (force_in_range && (force_sel_ext == (SEL_W + 1)'(i))) begin
                eligible[i] = in_valid[i];
            end
        end
    end

    // Fixed priority is the round-robin search anchored at index 0.
    assign search_base = ptr_q & {SEL_W{RR_EN}};

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        cand        = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            cand = SEL_W'((32'(search_base) + k) % CHANNELS);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant       = cand;
            end
        end
    end

    assign transfer = grant_valid && load;

    always_comb begin
        in_ready = '0;
        if (transfer && !reset) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (transfer) begin
            valid_d = 1'b1;
            data_d  = in_data[grant*WIDTH +: WIDTH];
            sel_d   = grant;
            ptr_d   = (grant == LAST_SEL) ? '0 : grant + 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: 8-channel instance against a reference model, plus a
// 6-channel instance for out-of-range forced selects. Honours ARB_MUX_ROUND_ROBIN_EN.
module tb_arb_mux;

    typedef struct packed {
        logic [2:0]  sel;
        logic [15:0] data;
    } sb_t;

    logic         clk;
    logic         reset;
    logic [127:0] in_data;
    logic [7:0]   in_valid;
    logic [7:0]   in_ready;
    logic         force_en;
    logic [2:0]   force_sel;
    logic [15:0]  out_data;
    logic [2:0]   out_sel;
    logic         out_valid;
    logic         out_ready;

    logic [95:0]  in_data6;
    logic [5:0]   in_valid6;
    logic [5:0]   in_ready6;
    logic         force_en6;
    logic [2:0]   force_sel6;
    logic [15:0]  out_data6;
    logic [2:0]   out_sel6;
    logic         out_valid6;
    logic         out_ready6;

    int  total;
    int  bad;
    sb_t sb[$];
    logic m_valid;
    int   m_ptr;

    arb_mux #(.WIDTH(16), .CHANNELS(8)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .force_en  (force_en),
        .force_sel (force_sel),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    arb_mux #(.WIDTH(16), .CHANNELS(6)) u_dut6 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data6),
        .in_valid  (in_valid6),
        .in_ready  (in_ready6),
        .force_en  (force_en6),
        .force_sel (force_sel6),
        .out_data  (out_data6),
        .out_sel   (out_sel6),
        .out_valid (out_valid6),
        .out_ready (out_ready6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [7:0] v, input logic fe, input int fs,
                                       input int p);
        int r;
        r = -1;
        if (fe) begin
            if (fs < 8 && v[fs]) r = fs;
        end else begin
            for (int k = 0; k < 8; k++) begin
`ifdef ARB_MUX_ROUND_ROBIN_EN
                if (r < 0 && v[(p + k) % 8]) r = (p + k) % 8;
`else
                if (r < 0 && v[k]) r = k;
`endif
            end
        end
        return r;
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_ptr   = 0;
        sb.delete();
    endfunction

    task automatic set_word(input int ch, input logic [15:0] w);
        in_data[ch*16 +: 16] = w;
    endtask

    // Called just after a rising edge; checks the cycle at the falling edge and advances the model.
    task automatic run_cycle();
        int         g;
        logic       load;
        logic [7:0] exp_ready;
        sb_t        e;
        @(negedge clk);
        g         = model_grant(in_valid, force_en, int'(force_sel), m_ptr);
        load      = !m_valid || out_ready;
        exp_ready = '0;
        if (g >= 0 && load) exp_ready[g] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            if (sb.size() == 0) begin
                check("sb_underrun", 32'(sb.size()), 32'd1);
            end else begin
                check("out_data", 32'(out_data), 32'(sb[0].data));
                check("out_sel", 32'(out_sel), 32'(sb[0].sel));
                if (out_ready) void'(sb.pop_front());
            end
        end
        if (g >= 0 && load) begin
            e.sel  = 3'(g);
            e.data = in_data[g*16 +: 16];
            sb.push_back(e);
            m_valid = 1'b1;
            m_ptr   = (g + 1) % 8;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        in_data    = '0;
        in_valid   = '0;
        force_en   = 1'b0;
        force_sel  = '0;
        out_ready  = 1'b0;
        in_data6   = '0;
        in_valid6  = '0;
        force_en6  = 1'b0;
        force_sel6 = '0;
        out_ready6 = 1'b1;
        model_reset();
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Contention: every channel valid with distinct words.
        for (int i = 0; i < 8; i++) set_word(i, 16'hA000 + 16'(i));
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) run_cycle();

        // Single channel.
        in_valid = 8'b0000_0100;
        set_word(2, 16'hBEEF);
        run_cycle();
        in_valid = '0;
        run_cycle();

        // Back-pressure: ch5 word stalls, next word loads on the take.
        in_valid  = 8'b0010_0000;
        set_word(5, 16'h1234);
        out_ready = 1'b0;
        run_cycle();
        set_word(5, 16'h5678);
        for (int c = 0; c < 3; c++) run_cycle();
        out_ready = 1'b1;
        run_cycle();
        in_valid = '0;
        run_cycle();
        run_cycle();

        // Forced mode.
        force_en  = 1'b1;
        force_sel = 3'd3;
        set_word(1, 16'h1111);
        set_word(3, 16'h3333);
        in_valid  = 8'b0000_1010;
        run_cycle();
        in_valid  = 8'b0000_0010;
        run_cycle();
        run_cycle();
        force_en  = 1'b0;

        // Random traffic.
        for (int c = 0; c < 300; c++) begin
            in_valid = 8'($urandom);
            for (int i = 0; i < 8; i++) set_word(i, 16'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            force_en  = ($urandom_range(0, 7) == 0);
            force_sel = 3'($urandom_range(0, 7));
            run_cycle();
        end
        force_en = 1'b0;

        // Out-of-range forced select on the 6-channel instance.
        for (int i = 0; i < 6; i++) in_data6[i*16 +: 16] = 16'h6000 + 16'(i);
        in_valid6  = 6'h3F;
        force_en6  = 1'b1;
        force_sel6 = 3'd7;
        @(negedge clk);
        check("ch6_oor_in_ready", 32'(in_ready6), 32'd0);
        @(posedge clk);
        #1;
        check("ch6_oor_out_valid", 32'(out_valid6), 32'd0);
        force_sel6 = 3'd5;
        @(negedge clk);
        check("ch6_sel5_in_ready", 32'(in_ready6), 32'h20);
        @(posedge clk);
        #1;
        check("ch6_sel5_out_valid", 32'(out_valid6), 32'd1);
        check("ch6_sel5_out_sel", 32'(out_sel6), 32'd5);
        check("ch6_sel5_out_data", 32'(out_data6), 32'h6005);

        // Reset asserted mid-stream while a word is held.
        in_valid  = 8'b0001_0000;
        set_word(4, 16'hCAFE);
        out_ready = 1'b0;
        run_cycle();
        run_cycle();
        #3;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_sel", 32'(out_sel), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) set_word(i, 16'hD000 + 16'(i));
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_grant", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("post_rst_out_sel", 32'(out_sel), 32'd0);
        check("post_rst_out_data", 32'(out_data), 32'hD000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
